jtag_host: RTL and testbench
============================

JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL have parameter DW, default 64, max scan length and command/response data width.
REQ-002 SHALL have parameter LW, default 7, width of cmd_len (holds 0..DW).
REQ-003 SHALL have TCK  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have TRST_N  input  1  asynchronous active-low reset.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  host idle and able to accept a command.
REQ-007 SHALL have cmd_op  input  2  operation: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = reserved.
REQ-008 SHALL have cmd_len  input  LW  scan length in bits.
REQ-009 SHALL have cmd_data  input  DW  bits shifted out on TMS/TDI path, LSB first.
REQ-010 SHALL have rsp_valid  output  1  response available.
REQ-011 SHALL have rsp_ready  input  1  response consumed.
REQ-012 SHALL have rsp_data  output  DW  captured TDO bits, LSB first, unused upper bits 0.
REQ-013 SHALL have rsp_err  output  1  command rejected (bad op or length).
REQ-014 SHALL have TMS, TDI  output  1 each  registered drive into the TAP chain; TDO  input  1  last-chip output.

Function
REQ-015 SHALL accept a command on the rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 0 from that edge until the response is consumed.
REQ-016 SHALL register each TMS/TDI value one edge before the target consumes it; the first value is registered on the edge after acceptance (edge A+1, consumed A+2).
REQ-017 SHALL track the TAP state internally; between commands the chain SHALL be held in Run-Test/Idle with TMS=0, TDI=0.
REQ-018 TAP reset op SHALL drive TMS sequence 1,1,1,1,1,0 (TDI=0); rsp_valid at A+7, rsp_data=0.
REQ-019 DR scan SHALL drive TMS 1,0,0, then cmd_len shift values (0 for all but the last, 1 for the last), then 1,0; rsp_valid at A+cmd_len+6.
REQ-020 IR scan SHALL drive TMS 1,1,0,0, then the shift values as REQ-019, then 1,0; rsp_valid at A+cmd_len+7.
REQ-021 During shift value i (0-based), TDI SHALL equal cmd_data[i]; outside shift values TDI SHALL be 0.
REQ-022 SHALL sample TDO on the edge at which the target consumes shift value i and store it in rsp_data[i].
REQ-023 cmd_len=0, cmd_len>DW, or cmd_op=3 SHALL produce no TMS/TDI activity; rsp_valid=1 with rsp_err=1, rsp_data=0 on A+1.
REQ-024 rsp_valid, rsp_data and rsp_err SHALL hold stable until rsp_ready=1; cmd_ready SHALL return to 1 on the edge after the handshake.
REQ-025 A command with cmd_valid held SHALL be accepted on the edge cmd_ready rises; no cycle is lost.
REQ-026 State machine SHALL be IDLE -> PRE (path into Shift) -> SHIFT (bit counter 0..cmd_len-1) -> POST (Exit1, Update, Idle) -> RESP -> IDLE; reset op uses PRE then RESP.

Reset
REQ-027 TRST_N=0 SHALL immediately force TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, state IDLE.
REQ-028 On TRST_N deassertion the host SHALL, without a command, drive TMS 1,1,1,1,1,0, then raise cmd_ready on the 7th edge.
REQ-029 Reset mid-scan SHALL abort the scan, discard partial data and produce no response.

Configuration
REQ-030 Macro JTAG_HOST_IDLE_PAD_EN defined: after the final TMS=0 of every op, the host SHALL hold two extra Run-Test/Idle cycles (TMS=0), delaying rsp_valid by 2 edges.
REQ-031 Macro JTAG_HOST_IDLE_PAD_EN undefined: no padding; latencies exactly as REQ-018..020.

Verification
REQ-032 Release TRST_N -> TMS 1,1,1,1,1,0 observed, cmd_ready=1 on the 7th edge.
REQ-033 DR scan len=8 data=0xA5, TDO tied 1 -> TDI shifts 1,0,1,0,0,1,0,1, rsp_data=0xFF, rsp_valid at A+14.
REQ-034 IR scan len=4 data=0x3, TDO = TDI delayed 1 edge (preload 0) -> rsp_data=0x6, rsp_valid at A+11.
REQ-035 cmd_len=0 -> rsp_err=1, rsp_data=0 at A+1, TMS stays 0; rsp_ready held 0 for 5 cycles -> response stable, cmd_ready=0.
REQ-036 TRST_N pulsed low at shift bit 3 of len=16 DR scan -> TMS=1 immediately, no rsp_valid, reset sequence replayed.

Source files
------------

// File: rtl/jtag_host.sv
// jtag_host: command-driven JTAG TAP host issuing TAP reset, IR scans and DR scans.
// Optional macro JTAG_HOST_IDLE_PAD_EN appends two Run-Test/Idle cycles to every op.
module jtag_host #(
  parameter int DW = 64,
  parameter int LW = 7
) (
  input  logic          TCK,
  input  logic          TRST_N,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          TMS,
  output logic          TDI,
  input  logic          TDO
);
`ifdef JTAG_HOST_IDLE_PAD_EN
  localparam logic [3:0] PAD = 4'd2;
`else
  localparam logic [3:0] PAD = 4'd0;
`endif
  localparam logic [1:0]    OP_RST  = 2'd0;
  localparam logic [1:0]    OP_IR   = 2'd1;
  localparam logic [1:0]    OP_DR   = 2'd2;
  localparam logic [LW-1:0] LEN_MAX = LW'(DW);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

  state_t        r_state, w_state_n;
  logic [3:0]    r_cnt, w_cnt_n;
  logic [LW-1:0] r_bit, w_bit_n;
  logic [LW-1:0] r_len, r_smp_idx;
  logic [1:0]    r_op;
  logic [DW-1:0] r_sh, r_rsp_data;
  logic          r_init, r_err, r_rsp_valid, r_tms, r_tdi, r_smp_en;
  logic          w_tms_n, w_tdi_n, w_accept, w_bad, w_pre_last, w_shift_last;

  assign cmd_ready    = (r_state == S_IDLE) && !r_init;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_bad        = (cmd_op == 2'd3) || (cmd_len == '0) || (cmd_len > LEN_MAX);
  assign w_shift_last = (r_bit == r_len - 1'b1);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_valid && r_err;
  assign rsp_data     = r_rsp_data;
  assign TMS          = r_tms;
  assign TDI          = r_tdi;

  // Last PRE step: reset walks 5 ones + 0 (+pad), IR needs 1,1,0,0, DR needs 1,0,0.
  always_comb begin
    case (r_op)
      OP_IR:   w_pre_last = (r_cnt == 4'd3);
      OP_DR:   w_pre_last = (r_cnt == 4'd2);
      default: w_pre_last = (r_cnt == 4'd5 + PAD);
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_tms_n   = 1'b0;
    w_tdi_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_init) begin
          // TMS is already 1 out of reset, so the boot walk starts one step in.
          w_tms_n   = 1'b1;
          w_cnt_n   = 4'd1;
          w_state_n = S_PRE;
        end else if (w_accept) begin
          w_cnt_n   = 4'd0;
          w_bit_n   = '0;
          w_state_n = w_bad ? S_RESP : S_PRE;
        end
      end
      S_PRE: begin
        case (r_op)
          OP_IR:   w_tms_n = (r_cnt < 4'd2);
          OP_DR:   w_tms_n = (r_cnt == 4'd0);
          default: w_tms_n = (r_cnt < 4'd5);
        endcase
        w_cnt_n = r_cnt + 4'd1;
        if (w_pre_last) begin
          w_cnt_n   = 4'd0;
          w_state_n = (r_op == OP_RST) ? S_RESP : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_tms_n = w_shift_last;
        w_tdi_n = r_sh[0];
        w_bit_n = r_bit + 1'b1;
        if (w_shift_last) w_state_n = S_POST;
      end
      S_POST: begin
        w_tms_n = (r_cnt == 4'd0);
        w_cnt_n = r_cnt + 4'd1;
        if (r_cnt == 4'd1 + PAD) w_state_n = S_RESP;
      end
      S_RESP: begin
        if (r_init || (r_rsp_valid && rsp_ready)) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_bit       <= '0;
      r_len       <= '0;
      r_op        <= OP_RST;
      r_sh        <= '0;
      r_rsp_data  <= '0;
      r_init      <= 1'b1;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_smp_en    <= 1'b0;
      r_smp_idx   <= '0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_tms     <= w_tms_n;
      r_tdi     <= w_tdi_n;
      // TDO belongs to the shift value the target consumes this edge, i.e. last edge's bit.
      r_smp_en  <= (r_state == S_SHIFT);
      r_smp_idx <= r_bit;
      if (r_smp_en)
        for (int i = 0; i < DW; i++)
          if (r_smp_idx == LW'(i)) r_rsp_data[i] <= TDO;
      if (r_state == S_SHIFT) r_sh <= r_sh >> 1;
      if (w_accept) begin
        r_op       <= cmd_op;
        r_len      <= cmd_len;
        r_sh       <= cmd_data;
        r_rsp_data <= '0;
        r_err      <= w_bad;
      end
      if (r_state == S_RESP) begin
        if (r_init) r_init <= 1'b0;
        else if (!r_rsp_valid) r_rsp_valid <= 1'b1;
        else if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_err       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_host.sv
// Directed testbench for jtag_host: boot walk, IR/DR scans, rejects, back-to-back, mid-scan reset.
module tb_jtag_host;
  localparam int DW = 64;
  localparam int LW = 7;

  logic          TCK = 1'b0, TRST_N = 1'b0;
  logic          cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready, rsp_valid, rsp_err, TMS, TDI, TDO;
  logic [DW-1:0] rsp_data;
  logic          tdo_q = 1'b0, tdo_dly = 1'b0;
  int            checks = 0, errors = 0;

  always #5 TCK = ~TCK;
  // Loopback model: a one-flop chain (TDO = TDI delayed one edge) or TDO tied high.
  always @(posedge TCK) tdo_q <= TDI;
  assign TDO = tdo_dly ? tdo_q : 1'b1;

  jtag_host #(.DW(DW), .LW(LW)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  task automatic tick;
    @(posedge TCK); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [DW-1:0] data);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready); end
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:1] tms_v, rdy_v;
    TRST_N = 1'b0;
    #12;
    checks++;
    if ({TMS, TDI, cmd_ready, rsp_valid, rsp_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_outs: tms/tdi/rdy/vld/err=%b required 10000", {TMS, TDI, cmd_ready, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: rsp_data=%h required 0", rsp_data); end
    @(negedge TCK); TRST_N = 1'b1;
    for (int k = 1; k <= 7; k++) begin tick(); tms_v[k] = TMS; rdy_v[k] = cmd_ready; end
    checks++;
    if (tms_v !== 7'b0011111) begin errors++; $display("FAIL boot_tms: seq(k7..k1)=%b required 0011111", tms_v); end
    checks++;
    if (rdy_v !== 7'b1000000) begin errors++; $display("FAIL boot_ready: seq(k7..k1)=%b required 1000000", rdy_v); end
  endtask

  task automatic test_dr_scan;
    logic [14:1] tms_v, tdi_v, vld_v;
    tdo_dly = 1'b0;
    issue(2'd2, 7'd8, 64'hA5);
    for (int k = 1; k <= 14; k++) begin tick(); tms_v[k] = TMS; tdi_v[k] = TDI; vld_v[k] = rsp_valid; end
    checks++;
    if (tms_v !== 14'b00110000000001) begin errors++; $display("FAIL dr_tms: seq=%b required 00110000000001", tms_v); end
    checks++;
    if (tdi_v !== 14'b00010100101000) begin errors++; $display("FAIL dr_tdi: seq=%b required 00010100101000", tdi_v); end
    checks++;
    if (vld_v !== 14'b10000000000000) begin errors++; $display("FAIL dr_valid: seq=%b required 10000000000000", vld_v); end
    checks++;
    if (rsp_data !== 64'hFF || rsp_err !== 1'b0) begin
      errors++; $display("FAIL dr_data: data=%h err=%b required 00000000000000ff err=0", rsp_data, rsp_err);
    end
    consume();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL dr_handshake: vld/rdy=%b required 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_ir_scan;
    logic [11:1] tms_v, tdi_v, vld_v;
    tdo_dly = 1'b1;
    issue(2'd1, 7'd4, 64'h3);
    for (int k = 1; k <= 11; k++) begin tick(); tms_v[k] = TMS; tdi_v[k] = TDI; vld_v[k] = rsp_valid; end
    checks++;
    if (tms_v !== 11'b00110000011) begin errors++; $display("FAIL ir_tms: seq=%b required 00110000011", tms_v); end
    checks++;
    if (tdi_v !== 11'b00000110000) begin errors++; $display("FAIL ir_tdi: seq=%b required 00000110000", tdi_v); end
    checks++;
    if (vld_v !== 11'b10000000000) begin errors++; $display("FAIL ir_valid: seq=%b required 10000000000", vld_v); end
    checks++;
    if (rsp_data !== 64'h6) begin errors++; $display("FAIL ir_data: data=%h required 6", rsp_data); end
    consume();
    tdo_dly = 1'b0;
  endtask

  task automatic test_max_len;
    logic [DW-1:0] tdi_cap;
    int first;
    tdi_cap = '0; first = 0;
    issue(2'd2, 7'd64, 64'h0123456789ABCDEF);
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k >= 4 && k <= 67) tdi_cap[k-4] = TDI;
      if (rsp_valid === 1'b1 && first == 0) first = k;
    end
    checks++;
    if (first != 70) begin errors++; $display("FAIL max_latency: valid at A+%0d required A+70", first); end
    checks++;
    if (tdi_cap !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL max_tdi: shifted=%h required 0123456789abcdef", tdi_cap); end
    checks++;
    if (rsp_data !== {DW{1'b1}} || rsp_err !== 1'b0) begin
      errors++; $display("FAIL max_data: data=%h err=%b required all ones err=0", rsp_data, rsp_err);
    end
    consume();
  endtask

  task automatic test_errors;
    logic ok;
    issue(2'd2, 7'd0, 64'hFFFF);
    tick();
    checks++;
    if ({rsp_valid, rsp_err, TMS} !== 3'b110 || rsp_data !== '0) begin
      errors++; $display("FAIL err_len0: vld/err/tms=%b data=%h required 110 data 0", {rsp_valid, rsp_err, TMS}, rsp_data);
    end
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || cmd_ready !== 1'b0 || TMS !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL err_hold: stable=%b required 1", ok); end
    consume();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL err_release: vld/rdy=%b required 01", {rsp_valid, cmd_ready}); end
    issue(2'd1, 7'd65, 64'h1);
    tick();
    checks++;
    if ({rsp_valid, rsp_err, TMS} !== 3'b110) begin errors++; $display("FAIL err_len65: vld/err/tms=%b required 110", {rsp_valid, rsp_err, TMS}); end
    consume();
    issue(2'd3, 7'd8, 64'h1);
    tick();
    checks++;
    if ({rsp_valid, rsp_err, TMS} !== 3'b110) begin errors++; $display("FAIL err_op3: vld/err/tms=%b required 110", {rsp_valid, rsp_err, TMS}); end
    consume();
  endtask

  task automatic test_back_to_back;
    logic [7:1] tms_v, vld_v;
    issue(2'd0, 7'd1, 64'h0);
    for (int k = 1; k <= 7; k++) begin tick(); tms_v[k] = TMS; vld_v[k] = rsp_valid; end
    checks++;
    if (tms_v !== 7'b0011111) begin errors++; $display("FAIL rstop_tms: seq=%b required 0011111", tms_v); end
    checks++;
    if (vld_v !== 7'b1000000 || rsp_data !== '0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rstop_rsp: vld seq=%b data=%h err=%b required 1000000 data 0 err 0", vld_v, rsp_data, rsp_err);
    end
    cmd_op = 2'd3; cmd_len = 7'd1; cmd_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL b2b_ready: vld/rdy=%b required 01", {rsp_valid, cmd_ready}); end
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: cmd_ready=%b required 0", cmd_ready); end
    tick();
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b11) begin errors++; $display("FAIL b2b_rsp: vld/err=%b required 11", {rsp_valid, rsp_err}); end
    consume();
  endtask

  task automatic test_reset_mid;
    logic [7:1] tms_v, rdy_v;
    logic       seen;
    tdo_dly = 1'b0; seen = 1'b0;
    issue(2'd2, 7'd16, 64'hFFFF);
    for (int k = 1; k <= 7; k++) tick();
    #2 TRST_N = 1'b0;
    #1;
    checks++;
    if ({TMS, TDI, cmd_ready, rsp_valid, rsp_err} !== 5'b10000 || rsp_data !== '0) begin
      errors++; $display("FAIL mid_reset: tms/tdi/rdy/vld/err=%b data=%h required 10000 data 0",
                         {TMS, TDI, cmd_ready, rsp_valid, rsp_err}, rsp_data);
    end
    @(negedge TCK); TRST_N = 1'b1;
    for (int k = 1; k <= 7; k++) begin tick(); tms_v[k] = TMS; rdy_v[k] = cmd_ready; if (rsp_valid) seen = 1'b1; end
    checks++;
    if (tms_v !== 7'b0011111 || rdy_v !== 7'b1000000) begin
      errors++; $display("FAIL mid_replay: tms=%b rdy=%b required 0011111 1000000", tms_v, rdy_v);
    end
    for (int k = 0; k < 20; k++) begin tick(); if (rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_norsp: rsp_valid seen=%b required 0", seen); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dr_scan();
    test_ir_scan();
    test_max_len();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
